// File: rtl/dds_wave_gen.sv
// Direct digital synthesis waveform generator: phase accumulator, external
// synchronous sine ROM and sine/square/triangle/sawtooth output shaping.
module dds_wave_gen #(
  parameter int ACC_W   = 32,
  parameter int PHASE_W = 12,
  parameter int DATA_W  = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [3:0]         wave_sel,
  input  logic [ACC_W-1:0]   freq_word,
  input  logic [PHASE_W-1:0] phase_off,
  output logic [PHASE_W-1:0] rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  dds_out
);

  localparam logic [3:0] SEL_SINE = 4'b0001;

  logic [ACC_W-1:0]   acc;
  logic [ACC_W:0]     sum;
  logic               wrap;
  logic               req_ok;
  logic [PHASE_W-1:0] phase_c;
  logic [PHASE_W-1:0] ph1;
  logic [PHASE_W-1:0] ph2;
  logic [3:0]         sel_req;
  logic [3:0]         sel_act;
  logic [3:0]         sel1;
  logic [3:0]         sel2;
  logic [DATA_W-1:0]  wave;

  assign sum     = {1'b0, acc} + {1'b0, freq_word};
  assign wrap    = sum[ACC_W];
  assign req_ok  = (wave_sel != 4'd0) &&
                   ((wave_sel & (wave_sel - 4'd1)) == 4'd0);
  assign phase_c = acc[ACC_W-1 -: PHASE_W] + phase_off;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc      <= '0;
      rom_addr <= '0;
      ph1      <= '0;
      ph2      <= '0;
      sel_req  <= SEL_SINE;
      sel_act  <= SEL_SINE;
      sel1     <= SEL_SINE;
      sel2     <= SEL_SINE;
      dds_out  <= '0;
    end else begin
      acc      <= sum[ACC_W-1:0];
      rom_addr <= phase_c;
      ph1      <= phase_c;
      ph2      <= ph1;
      sel1     <= sel_act;
      sel2     <= sel1;
      dds_out  <= wave;
      if (req_ok)
        sel_req <= wave_sel;
      // switch only at a period boundary; with no motion there is none
      if (wrap || (freq_word == '0))
        sel_act <= sel_req;
    end
  end

  always_comb begin
    wave = rom_data;
    unique case (1'b1)
      sel2[0]: wave = rom_data;
      sel2[1]: wave = {DATA_W{~ph2[PHASE_W-1]}};
      sel2[2]: wave = ph2[PHASE_W-1] ? ~ph2[PHASE_W-2 -: DATA_W]
                                     :  ph2[PHASE_W-2 -: DATA_W];
      sel2[3]: wave = ph2[PHASE_W-1 -: DATA_W];
      default: wave = rom_data;
    endcase
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen: expectations are queued against a
// cycle index and a negedge monitor compares them when that cycle arrives.
module tb_dds_wave_gen;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [3:0]  wave_sel;
  logic [31:0] freq_word;
  logic [11:0] phase_off;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic [7:0]  dds_out;

  int cyc = 0;
  int c0  = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int    cyc;
    int    kind;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];

  dds_wave_gen dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wave_sel  (wave_sel),
    .freq_word (freq_word),
    .phase_off (phase_off),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .dds_out   (dds_out)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // synchronous ROM whose contents are simply the low address byte
  always @(posedge sys_clk) rom_data <= rom_addr[7:0];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  function automatic logic [31:0] sample(input int kind);
    case (kind)
      0:       return {24'd0, dds_out};
      1:       return {20'd0, rom_addr};
      default: return {28'd0, dut.sel_act};
    endcase
  endfunction

  task automatic push(input int k, input int kind, input int val,
                      input string name);
    exp_t e;
    e.cyc  = c0 + k;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_k(input int k);
    while (cyc < c0 + k) @(negedge sys_clk);
  endtask

  task automatic release_rst();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    c0 = cyc;
  endtask

  always @(negedge sys_clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].name, sample(sb[i].kind), sb[i].val);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        check({sb[i].name, "_missed"}, 32'd1, 32'd0);
        sb.delete(i);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    wave_sel  = 4'b1000;
    freq_word = 32'h0010_0000;
    phase_off = 12'h000;
    repeat (3) @(negedge sys_clk);
    check("rst_dds_out",  {24'd0, dds_out},     32'h00);
    check("rst_rom_addr", {20'd0, rom_addr},    32'h000);
    check("rst_sel_act",  {28'd0, dut.sel_act}, 32'h1);

    // sawtooth ramp, then deferred switch to square
    release_rst();
    push(1,     1, 12'h000, "ramp_addr_k1");
    push(2,     1, 12'h001, "ramp_addr_k2");
    push(3,     1, 12'h002, "ramp_addr_k3");
    push(3,     0, 8'h00,   "first_sample_sine");
    push(4,     0, 8'h01,   "second_sample_sine");
    push(100,   0, 8'h61,   "sine_before_wrap");
    push(4096,  1, 12'hFFF, "addr_top");
    push(4097,  1, 12'h000, "addr_wrap");
    push(4098,  0, 8'hFF,   "sine_last");
    push(4099,  0, 8'h00,   "saw_first");
    push(4390,  0, 8'h12,   "saw_0x123");
    push(8179,  0, 8'hFF,   "saw_0xFF0");
    push(5121,  1, 12'h400, "addr_at_req");
    push(8000,  0, 8'hF3,   "saw_after_req");
    push(8178,  0, 8'hFE,   "saw_before_wrap");
    push(8195,  0, 8'hFF,   "square_first");
    push(10242, 0, 8'hFF,   "square_hi_end");
    push(10243, 0, 8'h00,   "square_lo_start");
    push(12547, 0, 8'hFF,   "multihot_ignored");
    wait_k(5121);
    wave_sel = 4'b0010;
    wait_k(8300);
    wave_sel = 4'b0011;
    wait_k(12547);

    // asynchronous reset in the middle of square output
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_dds_out",  {24'd0, dds_out},     32'h00);
    check("async_rst_rom_addr", {20'd0, rom_addr},    32'h000);
    check("async_rst_sel_act",  {28'd0, dut.sel_act}, 32'h1);
    wave_sel  = 4'b0010;
    freq_word = 32'h0100_0000;
    phase_off = 12'h000;
    repeat (2) @(negedge sys_clk);

    // sine from address 0, then square with a 256-cycle period
    release_rst();
    push(2,   1, 12'h010, "sq_addr_k2");
    push(3,   0, 8'h00,   "rst_sine_a0");
    push(4,   0, 8'h10,   "rst_sine_a10");
    push(5,   0, 8'h20,   "rst_sine_a20");
    push(258, 0, 8'hF0,   "sq_sine_last");
    push(259, 0, 8'hFF,   "sq_hi_first");
    push(386, 0, 8'hFF,   "sq_hi_last");
    push(387, 0, 8'h00,   "sq_lo_first");
    push(514, 0, 8'h00,   "sq_lo_last");
    push(515, 0, 8'hFF,   "sq_hi_again");
    wait_k(520);

    // triangle with a half-period phase offset
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    wave_sel  = 4'b0100;
    freq_word = 32'h0010_0000;
    phase_off = 12'h800;
    repeat (2) @(negedge sys_clk);
    release_rst();
    push(1,    1, 12'h800, "tri_addr_k1");
    push(3,    0, 8'h00,   "tri_sine_a800");
    push(4,    0, 8'h01,   "tri_sine_a801");
    push(4099, 0, 8'hFF,   "tri_phase0");
    push(5123, 0, 8'h7F,   "tri_phase400");
    push(6146, 0, 8'h00,   "tri_phase7ff");
    push(6147, 0, 8'h00,   "tri_phase800");
    push(6163, 0, 8'h02,   "tri_rising");
    wait_k(6170);

    // zero frequency: selection follows immediately, then speed up
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    wave_sel  = 4'b0001;
    freq_word = 32'h0;
    phase_off = 12'h123;
    repeat (2) @(negedge sys_clk);
    release_rst();
    push(5,  1, 12'h123, "zf_addr");
    push(10, 0, 8'h23,   "zf_sine");
    push(11, 2, 4'b0001, "zf_sel_old");
    push(12, 2, 4'b1000, "zf_sel_new");
    push(14, 0, 8'h23,   "zf_sine_hold");
    push(15, 0, 8'h12,   "zf_saw");
    push(26, 2, 4'b1000, "zf_multihot_sel");
    push(27, 0, 8'h12,   "zf_multihot_out");
    push(31, 1, 12'h123, "fw_change_k31");
    push(32, 1, 12'h124, "fw_change_k32");
    push(64, 0, 8'h14,   "fw_change_saw");
    wait_k(10);
    wave_sel = 4'b1000;
    wait_k(20);
    wave_sel = 4'b0110;
    wait_k(30);
    freq_word = 32'h0010_0000;
    wait_k(70);

    @(negedge sys_clk);
    if (sb.size() != 0)
      check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_wave_gen.md
DDS_WAVE_GEN -- requirements
Module: dds_wave_gen

Interface
REQ-001 Parameter: ACC_W, 32, phase accumulator width.
REQ-002 Parameter: PHASE_W, 12, truncated phase and ROM address width.
REQ-003 Parameter: DATA_W, 8, sample width, unsigned offset-binary.
REQ-004 Port: sys_clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port: sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Port: wave_sel  input  4  one-hot waveform request from the key control stage: 0001 sine, 0010 square, 0100 triangle, 1000 sawtooth.
REQ-007 Port: freq_word  input  ACC_W  frequency tuning word, sampled every cycle.
REQ-008 Port: phase_off  input  PHASE_W  phase offset added to the truncated phase, sampled every cycle.
REQ-009 Port: rom_addr  output  PHASE_W  registered address to the external sine ROM.
REQ-010 Port: rom_data  input  DATA_W  sine ROM data; ROM is synchronous, so rom_data(n+1) = ROM[rom_addr(n)].
REQ-011 Port: dds_out  output  DATA_W  registered waveform sample.

Function
REQ-012 Accumulator: acc <= acc + freq_word each cycle, modulo 2^ACC_W; wrap = carry out of that addition.
REQ-013 Stage 1: rom_addr <= acc[ACC_W-1 -: PHASE_W] + phase_off, modulo 2^PHASE_W; ph1 <= same value; sel1 <= sel_act.
REQ-014 Stage 2: ph2 <= ph1; sel2 <= sel1; rom_data is aligned with ph2.
REQ-015 Output: dds_out <= f(sel2, ph2, rom_data) registered, so dds_out lags rom_addr by exactly 2 cycles for the same phase.
REQ-016 Sine (0001): f = rom_data.
REQ-017 Square (0010): f = 8'hFF when ph2[11]=0, else 8'h00.
REQ-018 Triangle (0100): f = ph2[10:3] when ph2[11]=0, else ~ph2[10:3] (0x000->0x00, 0x7FF->0xFF, 0x800->0xFF, 0xFFF->0x00).
REQ-019 Sawtooth (1000): f = ph2[11:4].
REQ-020 Request capture: sel_req <= wave_sel only when wave_sel is exactly one-hot; any other value (0000, multi-hot) is ignored and sel_req holds.
REQ-021 Glitch-free switch: sel_act <= sel_req only in a cycle where wrap=1, so a waveform change takes effect at phase 0 of a new period.
REQ-022 Zero frequency: when freq_word=0, sel_act <= sel_req every cycle, since no wrap can occur.
REQ-023 Simultaneous events: a new wave_sel and wrap in the same cycle means sel_act takes the old sel_req; the new request applies at the next wrap.
REQ-024 Changes to freq_word or phase_off take effect on the next accumulator or stage-1 update, with no resynchronisation and no acc clear.

Reset
REQ-025 While sys_rst_n=0, all registers are held: acc=0, rom_addr=0, ph1=ph2=0, dds_out=8'h00, sel_req=sel_act=sel1=sel2=4'b0001 (sine, matching the upstream reset selection).
REQ-026 Reset asserted mid-operation clears all state immediately, regardless of the clock.
REQ-027 After release, the first acc update occurs on the first rising edge.
REQ-028 The first valid sample appears on dds_out 3 edges after release.

Verification
REQ-029 Sawtooth ramp: wave_sel=1000, freq_word=0x0010_0000, phase_off=0, ROM model data=addr[7:0]; apply reset, then wait for the first wrap so the sawtooth selection takes effect.
- Expected: rom_addr steps 0,1,2,... per cycle.
- Expected: dds_out = (rom_addr 2 cycles earlier)>>4.
- Expected: rom_addr wraps 0xFFF->0x000 after 4096 cycles.
REQ-030 Square: freq_word=0x0100_0000, wave_sel=0010 active.
- Expected: dds_out is 0xFF for 128 cycles, then 0x00 for 128 cycles, repeating.
REQ-031 Triangle and offset: freq_word=0x0010_0000, phase_off=0x800, wave_sel=0100 active.
- Expected: with acc phase 0, dds_out=0xFF.
- Expected: dds_out falls to 0x00 at acc phase 0x7FF, then rises again.
REQ-032 Deferred switch:
- Stimulus: sawtooth running at freq_word=0x0010_0000; set wave_sel=0010 when rom_addr=0x400.
- Expected: dds_out stays sawtooth until the acc wrap.
- Expected: the first sample with ph2=0x000 is 0xFF square.
- Stimulus: wave_sel=0011.
- Expected: no change.
REQ-033 Zero frequency: freq_word=0, wave_sel changes 0001->1000 with rom_addr=0x123.
- Expected: sel_act updates the next cycle.
- Expected: dds_out=0x12 three cycles later.
REQ-034 Reset mid-run: assert sys_rst_n=0 during square output.
- Expected: dds_out=0x00, rom_addr=0 and sel_act=0001 immediately, without waiting for a clock edge.
- Expected: after release, sine output uses ROM data from address 0 upward.
